instr_sequencer: RTL and testbench

Instruction-side driver for the single-instruction execute core. Holds a small program of 32-bit RV32 I-type words, fetches them in order, and decodes each into opcode/rd/rs1/imm12 fields. Issues each decoded instruction to the execute core over a valid/ready handshake, then waits for the core's result before advancing. Sits between the test/boot loader and the execute core, replacing the hand-driven instruction inputs.

---
 rtl/instr_sequencer.sv | 111 +++++++++++
 tb/tb_instr_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches, decodes and issues RV32 I-type words to the execute core one at a time.
// Define SEQ_RETIRE_CNT_EN to build the saturating retired-instruction counter.
module instr_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [31:0]      prog_data,
    input  logic             start,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [2:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [11:0]      imm12,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] result_data,
    output logic [WIDTH-1:0] last_result,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [15:0]      retired
);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, HALT} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [31:0] instr;
    logic        idle_or_halt;

    assign idle_or_halt = (state == IDLE) || (state == HALT);
    assign busy         = !idle_or_halt;

    // Program memory is deliberately left out of reset so a program survives an abort.
    always_ff @(posedge clk) begin
        if (prog_we && idle_or_halt) mem[prog_addr] <= prog_data;
        instr <= mem[pc];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            issue_valid <= 1'b0;
            opcode      <= '0;
            rd          <= '0;
            rs1         <= '0;
            imm12       <= '0;
            last_result <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
            retired     <= '0;
`endif
        end else begin
            case (state)
                IDLE, HALT: if (start) begin
                    state  <= FETCH;
                    pc     <= '0;
                    halted <= 1'b0;
                    err    <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
                    retired <= '0;
`endif
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    {imm12, rs1, opcode, rd} <= instr[31:7];
                    if (instr[6:0] == OP_IMM) begin
                        state       <= ISSUE;
                        issue_valid <= 1'b1;
                    end else begin
                        state  <= HALT;
                        halted <= 1'b1;
                        err    <= instr[6:0] != SYSTEM;
                    end
                end
                ISSUE: if (issue_ready) begin
                    state       <= WAIT;
                    issue_valid <= 1'b0;
                end
                WAIT: if (result_valid) begin
                    last_result <= result_data;
`ifdef SEQ_RETIRE_CNT_EN
                    retired <= retired + 16'(retired != 16'hFFFF);
`endif
                    if (pc == AW'(DEPTH - 1)) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SEQ_RETIRE_CNT_EN
    assign retired = '0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized stimulus against a program-level reference model of the sequencer.
module tb_instr_sequencer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0, reset = 1'b1, prog_we = 1'b0, start = 1'b0;
    logic             issue_ready = 1'b0, result_valid = 1'b0;
    logic [AW-1:0]    prog_addr = '0;
    logic [31:0]      prog_data = '0;
    logic [WIDTH-1:0] result_data = '0;
    logic             issue_valid, busy, halted, err;
    logic [2:0]       opcode;
    logic [4:0]       rd, rs1;
    logic [11:0]      imm12;
    logic [WIDTH-1:0] last_result;
    logic [AW-1:0]    pc;
    logic [15:0]      retired;

    instr_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .issue_valid(issue_valid), .issue_ready(issue_ready), .opcode(opcode),
        .rd(rd), .rs1(rs1), .imm12(imm12), .result_valid(result_valid), .result_data(result_data),
        .last_result(last_result), .pc(pc), .busy(busy), .halted(halted), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] mmem [DEPTH];
    logic [31:0] mw;
    logic [AW-1:0] exp_pc = '0;
    logic [WIDTH-1:0] exp_last = '0;
    logic [15:0] exp_ret = '0;
    bit done_last = 1'b0, mon_en = 1'b0;
    logic [24:0] iss [$];
    logic [31:0] res_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues the program must make: every leading OP-IMM word, up to the end of memory.
    function automatic int exp_issues();
        for (int p = 0; p < DEPTH; p++) if (mmem[p][6:0] != 7'h13) return p;
        return DEPTH;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            mw = mmem[exp_pc];
            check("pc", pc, exp_pc);
            check("last_result", last_result, exp_last);
            check("retired", retired, exp_ret);
            if (issue_valid) begin
                check("issue_legal", mw[6:0], 7'h13);
                check("opcode", opcode, mw[14:12]);
                check("rd", rd, mw[11:7]);
                check("rs1", rs1, mw[19:15]);
                check("imm12", imm12, mw[31:20]);
                check("busy_issuing", busy, 1);
            end
            if (halted) begin
                check("halt_expected", done_last || mw[6:0] != 7'h13, 1);
                check("err_at_halt", err, !done_last && mw[6:0] != 7'h73);
                check("busy_halted", busy, 0);
                check("valid_halted", issue_valid, 0);
            end else begin
                check("err_running", err, 0);
            end
        end
    end

    task automatic reset_checks();
        check("rst_valid", issue_valid, 0);
        check("rst_opcode", opcode, 0);
        check("rst_rd", rd, 0);
        check("rst_rs1", rs1, 0);
        check("rst_imm12", imm12, 0);
        check("rst_last", last_result, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_retired", retired, 0);
    endtask

    task automatic load(input int a, input logic [31:0] w);
        mon_en = 1'b0;
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = w;
        @(posedge clk); #1;
        prog_we = 1'b0;
        mmem[a] = w;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_pc = '0;
        done_last = 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
        exp_ret = '0;
`endif
        mon_en = 1'b1;
    endtask

    // Plays the execute core: stalls ready, injects stray strobes, returns one result per issue.
    task automatic run(input int hold, input int reset_at, input bit corrupt);
        int n, h;
        logic [31:0] d;
        iss.delete();
        pulse_start();
        check("busy_after_start", busy, 1);
        forever begin
            n = 0;
            while (!issue_valid && !halted && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) begin
                checks++; errors++;
                $display("FAIL wait_issue: no issue or halt after %0d cycles, limit 20", n);
                return;
            end
            if (halted) return;
            if (iss.size() >= DEPTH) begin
                checks++; errors++;
                $display("FAIL issue_limit: issue %0d seen, at most %0d allowed", iss.size() + 1, DEPTH);
                return;
            end
            iss.push_back({opcode, rd, rs1, imm12});
            h = hold < 0 ? int'($urandom_range(0, 3)) : hold;
            for (int k = 0; k < h; k++) begin
                result_valid = (k == 1);
                result_data = 32'hBAD0_0000 | k;
                start = (k == 2);
                @(posedge clk); #1;
            end
            start = 1'b0;
            issue_ready = 1'b1;
            result_valid = 1'($urandom_range(0, 1));
            result_data = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            issue_ready = 1'b0; result_valid = 1'b0;
            if (corrupt && iss.size() == 1) begin
                prog_we = 1'b1; prog_addr = AW'(DEPTH - 1); prog_data = 32'h00100073;
                @(posedge clk); #1;
                prog_we = 1'b0;
            end
            if (iss.size() == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                exp_pc = '0; exp_last = '0; exp_ret = '0; done_last = 1'b0;
                reset_checks();
                return;
            end
            n = int'($urandom_range(0, 2));
            repeat (n) begin @(posedge clk); #1; end
            d = res_q.size() != 0 ? res_q.pop_front() : $urandom;
            result_valid = 1'b1; result_data = d;
            @(posedge clk); #1;
            result_valid = 1'b0;
            exp_last = d;
`ifdef SEQ_RETIRE_CNT_EN
            if (exp_ret != 16'hFFFF) exp_ret++;
`endif
            if (exp_pc == AW'(DEPTH - 1)) done_last = 1'b1; else exp_pc++;
        end
    endtask

    initial begin
        logic [31:0] r;
        for (int p = 0; p < DEPTH; p++) mmem[p] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        reset_checks();

        load(0, 32'h00500093); load(1, 32'h00100073);
        res_q = '{32'd5};
        run(-1, 0, 0);
        check("t1_issue", iss[0], {3'd0, 5'd1, 5'd0, 12'h005});
        check("t1_last", last_result, 5);
        check("t1_halted", halted, 1);
        check("t1_err", err, 0);
        check("t1_pc", pc, 1);
        check("t1_issues", iss.size(), 1);

        load(1, 32'h00A0E113); load(2, 32'h00100073);
        res_q = '{32'd5, 32'd15};
        run(-1, 0, 0);
        check("t2_issue", iss[1], {3'd6, 5'd2, 5'd1, 12'h00A});
        check("t2_last", last_result, 15);
        check("t2_pc", pc, 2);
`ifdef SEQ_RETIRE_CNT_EN
        check("t2_retired", retired, 2);
`endif

        load(0, 32'h00000033);
        run(-1, 0, 0);
        check("t3_halted", halted, 1);
        check("t3_err", err, 1);
        check("t3_issues", iss.size(), 0);

        load(0, 32'h00500093);
        res_q = '{32'h11, 32'h22};
        run(5, 0, 0);
        check("t4_last", last_result, 32'h22);
        check("t4_issues", iss.size(), 2);

        for (int p = 0; p < DEPTH; p++) load(p, {12'(p + 1), 5'd1, 3'd0, 5'd1, 7'h13});
        run(-1, 0, 1);
        check("t5_issues", iss.size(), DEPTH);
        check("t5_pc", pc, DEPTH - 1);
        check("t5_halted", halted, 1);
        check("t5_err", err, 0);

        run(-1, 3, 0);
        check("t6_aborted_issues", iss.size(), 3);
        run(-1, 0, 0);
        check("t6_rerun_issues", iss.size(), DEPTH);
        check("t6_rerun_pc", pc, DEPTH - 1);

        repeat (6) begin
            for (int p = 0; p < DEPTH; p++) begin
                r = $urandom;
                n_sel: begin
                    int s;
                    s = int'($urandom_range(0, 19));
                    r[6:0] = s < 18 ? 7'h13 : (s == 18 ? 7'h73 : 7'h33);
                end
                load(p, r);
            end
            run(-1, 0, 0);
            check("rand_issues", iss.size(), exp_issues());
            check("rand_halted", halted, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
